// File: rtl/noc_route_decoder.sv
// NoC routing node: decodes the address field of each flit and steers it to one of two
// buffered output channels, with a buffered route-select token stream and debug counters.

module noc_route_decoder_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          pop;

    // Valid is forced low during reset, before the first reset edge has cleared the count.
    assign valid = rst_n && (count != '0);
    assign pop   = valid && ready;
    assign full  = (count == FULL_CNT);
    assign data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module noc_route_decoder #(
    parameter int                DATA_W     = 9,
    parameter int                ADDR_W     = 4,
    parameter int                ADDR_LSB   = 5,
    parameter logic [ADDR_W-1:0] NODE_ADDR  = 4'b1110,
    parameter logic [ADDR_W-1:0] NODE_MASK  = 4'b1110,
    parameter bit                LEAF       = 1'b1,
    parameter int                FIFO_DEPTH = 2,
    parameter int                SEL_DEPTH  = 4,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic              sel_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);
    function automatic int leading_ones(input logic [ADDR_W-1:0] m);
        int n;
        n = 0;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            if (m[i] && (n == ADDR_W - 1 - i)) begin
                n++;
            end
        end
        return n;
    endfunction

    localparam int TREE_K = leading_ones(NODE_MASK);

    if ((ADDR_LSB < 0) || (ADDR_LSB + ADDR_W > DATA_W)) begin : g_bad_addr
        $error("noc_route_decoder: address field exceeds DATA_W");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo
        $error("noc_route_decoder: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((SEL_DEPTH < 2) || ((SEL_DEPTH & (SEL_DEPTH - 1)) != 0)) begin : g_bad_sel
        $error("noc_route_decoder: SEL_DEPTH must be a power of 2 and >= 2");
    end

    logic dest;
    logic full0;
    logic full1;
    logic sel_full;
    logic accept;
    logic push0;
    logic push1;

    if (LEAF) begin : g_leaf
        logic [ADDR_W-1:0] addr;
        assign addr = in_data[ADDR_LSB+ADDR_W-1:ADDR_LSB];
        assign dest = ((addr & NODE_MASK) == NODE_ADDR) ? 1'b0 : 1'b1;
    end else if (TREE_K >= ADDR_W) begin : g_tree_full
        assign dest = 1'b0;
    end else begin : g_tree
        // The bit just below the mask's run of leading ones picks the subtree.
        assign dest = in_data[ADDR_LSB+ADDR_W-1-TREE_K];
    end

    assign in_ready = rst_n && !(dest ? full1 : full0) && !sel_full;
    assign accept   = in_valid && in_ready;
    assign push0    = accept && !dest;
    assign push1    = accept && dest;

    noc_route_decoder_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .data      (out0_data)
    );

    noc_route_decoder_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .data      (out1_data)
    );

    noc_route_decoder_fifo #(.W(1), .DEPTH(SEL_DEPTH)) u_sel_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (dest),
        .full      (sel_full),
        .valid     (sel_valid),
        .ready     (sel_ready),
        .data      (sel_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0 && (cnt0 != '1)) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (push1 && (cnt1 != '1)) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_noc_route_decoder.sv
// Bench for noc_route_decoder: a default leaf-mode node checked through a scoreboard, plus a
// tree-mode node with 2-bit counters for the tree decode and saturation scenarios.

module tb_noc_route_decoder;
    logic       clk;
    logic       rst_n;

    logic       a_in_valid, a_in_ready;
    logic [8:0] a_in_data;
    logic       a_out0_valid, a_out0_ready, a_out1_valid, a_out1_ready;
    logic [8:0] a_out0_data, a_out1_data;
    logic       a_sel_valid, a_sel_ready, a_sel_data;
    logic [15:0] a_cnt0, a_cnt1;

    logic       b_in_valid, b_in_ready;
    logic [8:0] b_in_data;
    logic       b_out0_valid, b_out0_ready, b_out1_valid, b_out1_ready;
    logic [8:0] b_out0_data, b_out1_data;
    logic       b_sel_valid, b_sel_ready, b_sel_data;
    logic [1:0] b_cnt0, b_cnt1;

    int assertions = 0;
    int failures   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       qs[$];
    logic [8:0] exp_d;
    logic       exp_s;

    noc_route_decoder u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out0_valid(a_out0_valid), .out0_ready(a_out0_ready), .out0_data(a_out0_data),
        .out1_valid(a_out1_valid), .out1_ready(a_out1_ready), .out1_data(a_out1_data),
        .sel_valid(a_sel_valid), .sel_ready(a_sel_ready), .sel_data(a_sel_data),
        .cnt0(a_cnt0), .cnt1(a_cnt1)
    );

    noc_route_decoder #(.LEAF(1'b0), .NODE_MASK(4'b1100), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out0_valid(b_out0_valid), .out0_ready(b_out0_ready), .out0_data(b_out0_data),
        .out1_valid(b_out1_valid), .out1_ready(b_out1_ready), .out1_data(b_out1_data),
        .sel_valid(b_sel_valid), .sel_ready(b_sel_ready), .sel_data(b_sel_data),
        .cnt0(b_cnt0), .cnt1(b_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic leaf_dest(input logic [8:0] d);
        logic [3:0] a;
        a = d[8:5];
        return ((a & 4'b1110) == 4'b1110) ? 1'b0 : 1'b1;
    endfunction

    // Scoreboard: record accepted flits and compare every transfer leaving node A.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            qs.delete();
        end else begin
            if (a_out0_valid && a_out0_ready) begin
                assertions++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL out0_unexpected: got %h, required no flit", a_out0_data);
                end else begin
                    exp_d = q0.pop_front();
                    if (a_out0_data !== exp_d) begin
                        failures++;
                        $display("[TB] FAIL out0_data: got %h, required %h", a_out0_data, exp_d);
                    end
                end
            end
            if (a_out1_valid && a_out1_ready) begin
                assertions++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL out1_unexpected: got %h, required no flit", a_out1_data);
                end else begin
                    exp_d = q1.pop_front();
                    if (a_out1_data !== exp_d) begin
                        failures++;
                        $display("[TB] FAIL out1_data: got %h, required %h", a_out1_data, exp_d);
                    end
                end
            end
            if (a_sel_valid && a_sel_ready) begin
                assertions++;
                if (qs.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL sel_unexpected: got %b, required no token", a_sel_data);
                end else begin
                    exp_s = qs.pop_front();
                    if (a_sel_data !== exp_s) begin
                        failures++;
                        $display("[TB] FAIL sel_data: got %b, required %b", a_sel_data, exp_s);
                    end
                end
            end
            if (a_in_valid && a_in_ready) begin
                if (leaf_dest(a_in_data)) q1.push_back(a_in_data);
                else                      q0.push_back(a_in_data);
                qs.push_back(leaf_dest(a_in_data));
            end
        end
    end

    // Present a flit to node A; returns at 1 time unit after the accepting edge.
    task automatic send_a(input logic [8:0] d, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (a_in_ready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [8:0] d, input int budget, output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        while (!ok && n < budget) begin
            @(negedge clk);
            if (b_in_ready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        assertions++;
        if ({a_in_ready, a_out0_valid, a_out1_valid, a_sel_valid} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_hold: ready/valids=%b, required 0000",
                     {a_in_ready, a_out0_valid, a_out1_valid, a_sel_valid});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        assertions++;
        if (a_cnt0 !== 16'd0 || a_cnt1 !== 16'd0 || b_cnt0 !== 2'd0 || b_cnt1 !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_counters: a=%0d/%0d b=%0d/%0d, required all 0",
                     a_cnt0, a_cnt1, b_cnt0, b_cnt1);
        end
        assertions++;
        if ({a_out0_valid, a_out1_valid, a_sel_valid, a_in_ready} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_release: valids/ready=%b, required 0001",
                     {a_out0_valid, a_out1_valid, a_sel_valid, a_in_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_leaf_routing;
        bit ok;
        logic [8:0] flits [3];
        flits[0] = 9'h1C3;
        flits[1] = 9'h1E0;
        flits[2] = 9'h0A5;
        for (int i = 0; i < 3; i++) begin
            send_a(flits[i], 10, ok);
            @(negedge clk);
            assertions++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL leaf_accept: flit %h not accepted, required accept", flits[i]);
            end else if (i < 2 && (a_out0_valid !== 1'b1 || a_out0_data !== flits[i])) begin
                failures++;
                $display("[TB] FAIL leaf_latency0: valid=%b data=%h, required 1 %h",
                         a_out0_valid, a_out0_data, flits[i]);
            end else if (i == 2 && (a_out1_valid !== 1'b1 || a_out1_data !== flits[i])) begin
                failures++;
                $display("[TB] FAIL leaf_latency1: valid=%b data=%h, required 1 %h",
                         a_out1_valid, a_out1_data, flits[i]);
            end
            @(posedge clk);
            #1;
        end
        drain(4);
        assertions++;
        if (a_cnt0 !== 16'd2 || a_cnt1 !== 16'd1) begin
            failures++;
            $display("[TB] FAIL leaf_counters: cnt0=%0d cnt1=%0d, required 2 1", a_cnt0, a_cnt1);
        end
        assertions++;
        if (q0.size() + q1.size() + qs.size() != 0) begin
            failures++;
            $display("[TB] FAIL leaf_drain: %0d items undelivered, required 0",
                     q0.size() + q1.size() + qs.size());
        end
    endtask

    task automatic test_backpressure;
        bit ok1, ok2, ok3, ok4;
        int refused;
        a_out0_ready = 1'b0;
        send_a(9'h1C3, 10, ok1);
        send_a(9'h1C3, 10, ok2);
        a_in_valid = 1'b1;
        a_in_data  = 9'h1C3;
        refused = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_in_ready === 1'b0) refused++;
        end
        assertions++;
        if (!ok1 || !ok2 || refused != 3) begin
            failures++;
            $display("[TB] FAIL bp_third_refused: accepts=%b%b refused=%0d/3, required 11 3/3",
                     ok1, ok2, refused);
        end
        assertions++;
        if (a_cnt1 !== 16'd1 || a_out1_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_isolation: cnt1=%0d out1_valid=%b, required 1 0",
                     a_cnt1, a_out1_valid);
        end
        @(posedge clk);
        #1;
        a_out0_ready = 1'b1;
        send_a(9'h1C3, 10, ok3);
        send_a(9'h0A5, 10, ok4);
        drain(6);
        assertions++;
        if (!ok3 || !ok4 || a_cnt0 !== 16'd5 || a_cnt1 !== 16'd2) begin
            failures++;
            $display("[TB] FAIL bp_release: accepts=%b%b cnt0=%0d cnt1=%0d, required 11 5 2",
                     ok3, ok4, a_cnt0, a_cnt1);
        end
        assertions++;
        if (q0.size() + q1.size() + qs.size() != 0) begin
            failures++;
            $display("[TB] FAIL bp_drain: %0d items undelivered, required 0",
                     q0.size() + q1.size() + qs.size());
        end
    endtask

    task automatic test_select_stall;
        bit ok;
        int accepted;
        int refused;
        logic [8:0] flits [4];
        flits[0] = 9'h1C3;
        flits[1] = 9'h0A5;
        flits[2] = 9'h1E0;
        flits[3] = 9'h0A5;
        a_sel_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            send_a(flits[i], 10, ok);
            if (ok) accepted++;
        end
        a_in_valid = 1'b1;
        a_in_data  = 9'h1C3;
        refused = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_in_ready === 1'b0) refused++;
        end
        assertions++;
        if (accepted != 4 || refused != 3) begin
            failures++;
            $display("[TB] FAIL sel_stall_refuse: accepted=%0d refused=%0d, required 4 3",
                     accepted, refused);
        end
        assertions++;
        if (a_out0_valid !== 1'b0 || a_out1_valid !== 1'b0 || a_sel_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sel_stall_data: out0/out1/sel valid=%b%b%b, required 001",
                     a_out0_valid, a_out1_valid, a_sel_valid);
        end
        @(posedge clk);
        #1;
        a_sel_ready = 1'b1;
        send_a(9'h1C3, 10, ok);
        drain(8);
        assertions++;
        if (!ok || a_cnt0 !== 16'd8 || a_cnt1 !== 16'd4 || qs.size() != 0) begin
            failures++;
            $display("[TB] FAIL sel_stall_release: ok=%b cnt0=%0d cnt1=%0d pending=%0d, required 1 8 4 0",
                     ok, a_cnt0, a_cnt1, qs.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2, ok3;
        int quiet;
        a_out0_ready = 1'b0;
        send_a(9'h1C3, 10, ok1);
        send_a(9'h1E0, 10, ok2);
        @(negedge clk);
        assertions++;
        if (!ok1 || !ok2 || a_out0_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_fill: accepts=%b%b out0_valid=%b, required 11 1",
                     ok1, ok2, a_out0_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        assertions++;
        if (a_in_ready !== 1'b0 || a_out0_valid !== 1'b0 || a_sel_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_hold: ready=%b out0_valid=%b sel_valid=%b, required 0 0 0",
                     a_in_ready, a_out0_valid, a_sel_valid);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a_out0_ready = 1'b1;
        @(negedge clk);
        assertions++;
        if (a_out0_valid !== 1'b0 || a_out1_valid !== 1'b0 || a_sel_valid !== 1'b0 ||
            a_cnt0 !== 16'd0 || a_cnt1 !== 16'd0) begin
            failures++;
            $display("[TB] FAIL rst_mid_cleared: valids=%b%b%b cnt0=%0d cnt1=%0d, required 000 0 0",
                     a_out0_valid, a_out1_valid, a_sel_valid, a_cnt0, a_cnt1);
        end
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_out0_valid === 1'b0) quiet++;
        end
        assertions++;
        if (quiet != 4) begin
            failures++;
            $display("[TB] FAIL rst_mid_discard: out0 quiet %0d/4 cycles, required 4/4", quiet);
        end
        @(posedge clk);
        #1;
        send_a(9'h0A5, 10, ok3);
        drain(4);
        assertions++;
        if (!ok3 || a_cnt0 !== 16'd0 || a_cnt1 !== 16'd1 || q1.size() != 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_resume: ok=%b cnt0=%0d cnt1=%0d pending=%0d, required 1 0 1 0",
                     ok3, a_cnt0, a_cnt1, q1.size());
        end
    endtask

    task automatic test_cnt_saturation;
        bit ok;
        logic [1:0] exp_c;
        for (int i = 0; i < 5; i++) begin
            send_b(9'h100 | 9'(i), 10, ok);
            exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
            @(negedge clk);
            assertions++;
            if (!ok || b_cnt0 !== exp_c) begin
                failures++;
                $display("[TB] FAIL cnt_saturation[%0d]: ok=%b cnt0=%0d, required 1 %0d",
                         i, ok, b_cnt0, exp_c);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_tree_mode;
        bit ok;
        send_b(9'h040, 10, ok);
        @(negedge clk);
        assertions++;
        if (!ok || b_out1_valid !== 1'b1 || b_out1_data !== 9'h040 || b_out0_valid !== 1'b0 ||
            b_sel_valid !== 1'b1 || b_sel_data !== 1'b1) begin
            failures++;
            $display("[TB] FAIL tree_bit_one: ok=%b out1=%b/%h out0_valid=%b sel=%b/%b, required 1 1/040 0 1/1",
                     ok, b_out1_valid, b_out1_data, b_out0_valid, b_sel_valid, b_sel_data);
        end
        @(posedge clk);
        #1;
        send_b(9'h000, 10, ok);
        @(negedge clk);
        assertions++;
        if (!ok || b_out0_valid !== 1'b1 || b_out0_data !== 9'h000 || b_out1_valid !== 1'b0 ||
            b_sel_valid !== 1'b1 || b_sel_data !== 1'b0) begin
            failures++;
            $display("[TB] FAIL tree_bit_zero: ok=%b out0=%b/%h out1_valid=%b sel=%b/%b, required 1 1/000 0 1/0",
                     ok, b_out0_valid, b_out0_data, b_out1_valid, b_sel_valid, b_sel_data);
        end
        @(posedge clk);
        #1;
        assertions++;
        if (b_cnt1 !== 2'd1 || b_cnt0 !== 2'd3) begin
            failures++;
            $display("[TB] FAIL tree_counters: cnt0=%0d cnt1=%0d, required 3 1", b_cnt0, b_cnt1);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        a_in_valid   = 1'b0;
        a_in_data    = '0;
        a_out0_ready = 1'b1;
        a_out1_ready = 1'b1;
        a_sel_ready  = 1'b1;
        b_in_valid   = 1'b0;
        b_in_data    = '0;
        b_out0_ready = 1'b1;
        b_out1_ready = 1'b1;
        b_sel_ready  = 1'b1;
        #1;
        test_reset();
        test_leaf_routing();
        test_backpressure();
        test_select_stall();
        test_reset_mid();
        test_cnt_saturation();
        test_tree_mode();
        drain(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
